// File: rtl/vga_ctrl_640x480.sv
// VGA 640x480@60Hz timing generator: free-running h/v counters produce sync, active flag,
// pixel address and RGB pins. Optional macro VGA_CTRL_BLANK_RGB_EN forces RGB to 0 outside the visible area.
module vga_ctrl_640x480 #(
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic [23:0] vga_data,
  output logic [9:0]  h_addr,
  output logic [9:0]  v_addr,
  output logic        hsync,
  output logic        vsync,
  output logic        valid,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
  localparam logic [9:0] H_ACT_START = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_ACT_END   = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);
  localparam logic [9:0] V_ACT_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_ACT_END   = 10'(V_SYNC + V_BP + V_ACTIVE);

  logic [9:0]  h_cnt_r;
  logic [9:0]  v_cnt_r;
  logic        h_valid_s;
  logic        v_valid_s;
  logic        valid_s;
  logic [23:0] rgb_s;

  // Horizontal pixel counter, wraps at the end of each line
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      h_cnt_r <= 10'd0;
    end else if (h_cnt_r == H_LAST) begin
      h_cnt_r <= 10'd0;
    end else begin
      h_cnt_r <= h_cnt_r + 10'd1;
    end
  end

  // Vertical line counter, advances only on the last pixel of a line
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      v_cnt_r <= 10'd0;
    end else if (h_cnt_r == H_LAST) begin
      if (v_cnt_r == V_LAST) begin
        v_cnt_r <= 10'd0;
      end else begin
        v_cnt_r <= v_cnt_r + 10'd1;
      end
    end else begin
      v_cnt_r <= v_cnt_r;
    end
  end

  // Sync, active-window and address decode straight from the counters
  always_comb begin
    h_valid_s = (h_cnt_r >= H_ACT_START) && (h_cnt_r < H_ACT_END);
    v_valid_s = (v_cnt_r >= V_ACT_START) && (v_cnt_r < V_ACT_END);
    valid_s   = h_valid_s && v_valid_s;
    valid     = valid_s;
    hsync     = (h_cnt_r < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    vsync     = (v_cnt_r < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    if (h_valid_s) begin
      h_addr = h_cnt_r - H_ACT_START;
    end else begin
      h_addr = 10'd0;
    end
    if (v_valid_s) begin
      v_addr = v_cnt_r - V_ACT_START;
    end else begin
      v_addr = 10'd0;
    end
  end

  // Colour path: frame-buffer read is combinational, so pixels go out with zero latency
  always_comb begin
    rgb_s = vga_data;
`ifdef VGA_CTRL_BLANK_RGB_EN
    if (valid_s) begin
      rgb_s = vga_data;
    end else begin
      rgb_s = 24'd0;
    end
`endif
    vga_r = rgb_s[23:16];
    vga_g = rgb_s[15:8];
    vga_b = rgb_s[7:0];
  end

endmodule

// File: tb/tb_vga_ctrl_640x480.sv
// Directed bench for vga_ctrl_640x480: full-size instance for line-level timing and colour,
// plus a reduced-geometry instance for frame timing and address decoding over whole frames.
module tb_vga_ctrl_640x480;

  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] vga_data = 24'h000000;
  logic [9:0]  h_addr, v_addr;
  logic        hsync, vsync, valid;
  logic [7:0]  vga_r, vga_g, vga_b;

  logic [23:0] s_data;
  logic [9:0]  s_h_addr, s_v_addr;
  logic        s_hsync, s_vsync, s_valid;
  logic [7:0]  s_r, s_g, s_b;

  int total = 0;
  int bad = 0;

  always #5 pclk = ~pclk;

  vga_ctrl_640x480 dut (
    .pclk(pclk), .reset(reset), .vga_data(vga_data),
    .h_addr(h_addr), .v_addr(v_addr), .hsync(hsync), .vsync(vsync), .valid(valid),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  // Reduced geometry: line 17 (active 7..14), frame 12 lines (active 5..9), frame = 204 cycles
  vga_ctrl_640x480 #(
    .H_SYNC(4), .H_BP(3), .H_ACTIVE(8), .H_FP(2),
    .V_SYNC(2), .V_BP(3), .V_ACTIVE(5), .V_FP(2), .SYNC_POL(1'b0)
  ) dut_small (
    .pclk(pclk), .reset(reset), .vga_data(s_data),
    .h_addr(s_h_addr), .v_addr(s_v_addr), .hsync(s_hsync), .vsync(s_vsync), .valid(s_valid),
    .vga_r(s_r), .vga_g(s_g), .vga_b(s_b)
  );

  // Address-encoding frame buffer for the small instance
  assign s_data = {s_v_addr, 4'h0, s_h_addr};

  // Leaves both counters at 0 on the current (falling-edge) sample point
  task automatic do_reset();
    @(negedge pclk);
    reset = 1'b1;
    @(negedge pclk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge pclk);
    reset = 1'b0;
    repeat (300) @(negedge pclk);
    reset = 1'b1;
    repeat (3) @(negedge pclk);
    total++; if (hsync !== 1'b0) begin bad++; $display("FAIL reset_hsync: got %b expected 0", hsync); end
    total++; if (vsync !== 1'b0) begin bad++; $display("FAIL reset_vsync: got %b expected 0", vsync); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", valid); end
    total++; if (h_addr !== 10'd0 || v_addr !== 10'd0) begin
      bad++; $display("FAIL reset_addr: got h=%0d v=%0d expected 0/0", h_addr, v_addr);
    end
    total++; if (s_hsync !== 1'b0 || s_vsync !== 1'b0 || s_valid !== 1'b0) begin
      bad++; $display("FAIL reset_small: got hs=%b vs=%b val=%b expected 0/0/0", s_hsync, s_vsync, s_valid);
    end
    reset = 1'b0;
    total++; if (hsync !== 1'b0 || vsync !== 1'b0 || valid !== 1'b0) begin
      bad++; $display("FAIL reset_first_cycle: got hs=%b vs=%b val=%b expected 0/0/0", hsync, vsync, valid);
    end
    repeat (95) @(negedge pclk);
    total++; if (hsync !== 1'b0) begin bad++; $display("FAIL reset_restart_h95: got %b expected 0", hsync); end
    @(negedge pclk);
    total++; if (hsync !== 1'b1) begin bad++; $display("FAIL reset_restart_h96: got %b expected 1", hsync); end
  endtask

  task automatic test_hsync();
    int low0, low1, rise0, rise1, fall0;
    logic prev;
    low0 = 0; low1 = 0; rise0 = -1; rise1 = -1; fall0 = -1;
    do_reset();
    prev = hsync;
    for (int i = 0; i < 1600; i++) begin
      if (i > 0) begin
        @(negedge pclk);
        if (prev === 1'b0 && hsync === 1'b1) begin
          if (rise0 < 0) rise0 = i; else if (rise1 < 0) rise1 = i;
        end
        if (prev === 1'b1 && hsync === 1'b0 && fall0 < 0) fall0 = i;
      end
      if (hsync === 1'b0) begin
        if (i < 800) low0++; else low1++;
      end
      prev = hsync;
    end
    total++; if (low0 != 96) begin bad++; $display("FAIL hsync_low_line0: got %0d expected 96", low0); end
    total++; if (low1 != 96) begin bad++; $display("FAIL hsync_low_line1: got %0d expected 96", low1); end
    total++; if (rise0 != 96) begin bad++; $display("FAIL hsync_high_start: got %0d expected 96", rise0); end
    total++; if (fall0 != 800) begin bad++; $display("FAIL hsync_fall: got %0d expected 800", fall0); end
    total++; if (rise1 - rise0 != 800) begin bad++; $display("FAIL hsync_period: got %0d expected 800", rise1 - rise0); end
  endtask

  task automatic test_first_last_pixel();
    do_reset();
    repeat (35 * 800 + 143) @(negedge pclk);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL pix_before_first: got %b expected 0", valid); end
    @(negedge pclk);
    total++; if (valid !== 1'b1 || h_addr !== 10'd0 || v_addr !== 10'd0) begin
      bad++; $display("FAIL pix_first: got val=%b h=%0d v=%0d expected 1/0/0", valid, h_addr, v_addr);
    end
    repeat (639) @(negedge pclk);
    total++; if (valid !== 1'b1 || h_addr !== 10'd639 || v_addr !== 10'd0) begin
      bad++; $display("FAIL pix_line_end: got val=%b h=%0d v=%0d expected 1/639/0", valid, h_addr, v_addr);
    end
    @(negedge pclk);
    total++; if (valid !== 1'b0 || h_addr !== 10'd0) begin
      bad++; $display("FAIL pix_after_end: got val=%b h=%0d expected 0/0", valid, h_addr);
    end
  endtask

  // Continues from h_cnt=784, v_cnt=35 (front porch)
  task automatic test_colour();
    logic [23:0] exp_blank;
`ifdef VGA_CTRL_BLANK_RGB_EN
    exp_blank = 24'h000000;
`else
    exp_blank = 24'hAABBCC;
`endif
    vga_data = 24'hAABBCC;
    #1;
    total++; if ({vga_r, vga_g, vga_b} !== exp_blank) begin
      bad++; $display("FAIL colour_blank: got %h expected %h", {vga_r, vga_g, vga_b}, exp_blank);
    end
    repeat (160) @(negedge pclk);
    total++; if (valid !== 1'b1 || vga_r !== 8'hAA || vga_g !== 8'hBB || vga_b !== 8'hCC) begin
      bad++; $display("FAIL colour_active: got val=%b rgb=%h expected 1/aabbcc", valid, {vga_r, vga_g, vga_b});
    end
    vga_data = 24'h123456;
    #1;
    total++; if (vga_r !== 8'h12 || vga_g !== 8'h34 || vga_b !== 8'h56) begin
      bad++; $display("FAIL colour_same_cycle: got %h expected 123456", {vga_r, vga_g, vga_b});
    end
  endtask

  task automatic test_small_frame();
    int vs_low, val_cnt, rise0, rise1;
    logic prev;
    logic first_ok, last_ok, after_ok;
    vs_low = 0; val_cnt = 0; rise0 = -1; rise1 = -1;
    first_ok = 1'b0; last_ok = 1'b0; after_ok = 1'b0;
    do_reset();
    prev = s_vsync;
    for (int i = 0; i < 612; i++) begin
      if (i > 0) begin
        @(negedge pclk);
        if (prev === 1'b0 && s_vsync === 1'b1) begin
          if (rise0 < 0) rise0 = i; else if (rise1 < 0) rise1 = i;
        end
      end
      if (i < 204 && s_vsync === 1'b0) vs_low++;
      if (i < 204 && s_valid === 1'b1) val_cnt++;
      if (i == 92) first_ok = (s_valid === 1'b1 && s_h_addr === 10'd0 && s_v_addr === 10'd0);
      if (i == 167) last_ok = (s_valid === 1'b1 && s_h_addr === 10'd7 && s_v_addr === 10'd4);
      if (i == 168) after_ok = (s_valid === 1'b0);
      prev = s_vsync;
    end
    total++; if (vs_low != 34) begin bad++; $display("FAIL frame_vsync_low: got %0d expected 34", vs_low); end
    total++; if (rise0 != 34) begin bad++; $display("FAIL frame_vsync_rise: got %0d expected 34", rise0); end
    total++; if (rise1 - rise0 != 204) begin bad++; $display("FAIL frame_period: got %0d expected 204", rise1 - rise0); end
    total++; if (val_cnt != 40) begin bad++; $display("FAIL frame_valid_count: got %0d expected 40", val_cnt); end
    total++; if (!first_ok) begin bad++; $display("FAIL frame_first_pixel: got 0 expected 1"); end
    total++; if (!last_ok) begin bad++; $display("FAIL frame_last_pixel: got 0 expected 1"); end
    total++; if (!after_ok) begin bad++; $display("FAIL frame_after_last: got 0 expected 1"); end
  endtask

  task automatic test_addressing();
    int h_m, v_m;
    logic exp_valid;
    logic [23:0] got;
    do_reset();
    for (int i = 0; i < 408; i++) begin
      if (i > 0) @(negedge pclk);
      h_m = i % 17;
      v_m = (i / 17) % 12;
      exp_valid = (h_m >= 7 && h_m < 15 && v_m >= 5 && v_m < 10);
      total++; if (s_valid !== exp_valid) begin
        bad++; $display("FAIL addr_valid: got %b expected %b at h=%0d v=%0d", s_valid, exp_valid, h_m, v_m);
      end
      if (exp_valid) begin
        got = {s_r, s_g, s_b};
        total++; if (got[23:14] !== 10'(v_m - 5) || got[13:10] !== 4'h0 || got[9:0] !== 10'(h_m - 7)) begin
          bad++; $display("FAIL addr_decode: got v=%0d h=%0d expected v=%0d h=%0d", got[23:14], got[9:0], v_m - 5, h_m - 7);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_hsync();
    test_first_last_pixel();
    test_colour();
    test_small_frame();
    test_addressing();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
